pin_input_monitor: RTL and testbench

//   Input-side counterpart of the board LED drivers. It samples NR_PINS

---
 rtl/pin_input_monitor_pkg.sv | 15 +
 rtl/pin_input_monitor_if.sv | 23 ++
 rtl/pin_input_monitor_debounce.sv | 66 ++++++
 rtl/pin_input_monitor.sv | 58 +++++
 tb/tb_pin_input_monitor.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/pin_input_monitor_pkg.sv
// Shared constants for the pin input monitor: clock frequency and ms-to-cycles helper.
package pin_input_monitor_pkg;

  localparam int unsigned CLK25_FREQ_HZ = 25_000_000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK25_FREQ_HZ / 1000) * ms;
  endfunction

  localparam int unsigned DEBOUNCE_MS          = 10;
  localparam int unsigned DEBOUNCE_CYCLES_DFLT = ms_to_cycles(DEBOUNCE_MS);
  localparam int unsigned NR_PINS_DFLT         = 4;
  localparam int unsigned EDGE_CNT_BITS_DFLT   = 16;

endpackage

// File: rtl/pin_input_monitor_if.sv
// Pad-side inputs and debounced results of the pin input monitor.
interface pin_input_monitor_if #(
  parameter int unsigned NR_PINS       = 4,
  parameter int unsigned EDGE_CNT_BITS = 16
);
  logic [NR_PINS-1:0]       pins_in;
  logic [NR_PINS-1:0]       clr_changed;
  logic [NR_PINS-1:0]       pins_stable;
  logic [NR_PINS-1:0]       rise;
  logic [NR_PINS-1:0]       fall;
  logic [NR_PINS-1:0]       changed;
  logic [EDGE_CNT_BITS-1:0] edge_cnt;

  modport master (
    output pins_in, clr_changed,
    input  pins_stable, rise, fall, changed, edge_cnt
  );

  modport slave (
    input  pins_in, clr_changed,
    output pins_stable, rise, fall, changed, edge_cnt
  );
endinterface

// File: rtl/pin_input_monitor_debounce.sv
// Single-pin 2-flop synchronizer and debouncer with registered rise/fall pulses.
module pin_debounce
  import pin_input_monitor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input  logic clk25,
  input  logic rst_,
  input  logic pin_in,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Any sample matching the accepted level restarts the count.
  always_comb begin
    sync1_d  = pin_in;
    sync2_d  = sync1_q;
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/pin_input_monitor.sv
// Debounces NR_PINS pad inputs and tracks sticky change flags and a wrapping edge count.
module pin_input_monitor
  import pin_input_monitor_pkg::*;
#(
  parameter int unsigned NR_PINS         = NR_PINS_DFLT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int unsigned EDGE_CNT_BITS   = EDGE_CNT_BITS_DFLT
) (
  input  logic                clk25,
  input  logic                rst_,
  pin_input_monitor_if.slave  mon
);

  logic [NR_PINS-1:0]       stable_w, rise_w, fall_w;
  logic [NR_PINS-1:0]       edges_c;
  logic [NR_PINS-1:0]       changed_q, changed_d;
  logic [EDGE_CNT_BITS-1:0] edge_cnt_q, edge_cnt_d;

  for (genvar g = 0; g < NR_PINS; g++) begin : g_pin
    pin_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk25  (clk25),
      .rst_   (rst_),
      .pin_in (mon.pins_in[g]),
      .stable (stable_w[g]),
      .rise   (rise_w[g]),
      .fall   (fall_w[g])
    );
  end

  // A new edge on a pin wins over a simultaneous clear of its flag.
  always_comb begin
    edges_c    = rise_w | fall_w;
    changed_d  = (changed_q & ~mon.clr_changed) | edges_c;
    edge_cnt_d = edge_cnt_q;
    for (int unsigned i = 0; i < NR_PINS; i++) begin
      edge_cnt_d = edge_cnt_d + EDGE_CNT_BITS'(edges_c[i]);
    end
  end

  always_ff @(posedge clk25 or negedge rst_) begin
    if (!rst_) begin
      changed_q  <= '0;
      edge_cnt_q <= '0;
    end else begin
      changed_q  <= changed_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign mon.pins_stable = stable_w;
  assign mon.rise        = rise_w;
  assign mon.fall        = fall_w;
  assign mon.changed     = changed_q;
  assign mon.edge_cnt    = edge_cnt_q;

endmodule

// File: tb/tb_pin_input_monitor.sv
// Directed bench for pin_input_monitor with DEBOUNCE_CYCLES=4, NR_PINS=4, EDGE_CNT_BITS=4.
module tb_pin_input_monitor;

  logic clk25 = 1'b0;
  logic rst_;
  int   n_checks = 0;
  int   n_errors = 0;

  always #20 clk25 = ~clk25;

  pin_input_monitor_if #(.NR_PINS(4), .EDGE_CNT_BITS(4)) mon ();

  pin_input_monitor #(
    .NR_PINS         (4),
    .DEBOUNCE_CYCLES (4),
    .EDGE_CNT_BITS   (4)
  ) dut (
    .clk25 (clk25),
    .rst_  (rst_),
    .mon   (mon)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk25);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stable"},  32'(mon.pins_stable), 32'h0);
    check({tag, "_rise"},    32'(mon.rise),        32'h0);
    check({tag, "_fall"},    32'(mon.fall),        32'h0);
    check({tag, "_changed"}, 32'(mon.changed),     32'h0);
    check({tag, "_cnt"},     32'(mon.edge_cnt),    32'h0);
  endtask

  initial begin
    int rise_at;
    int nrise;
    logic [3:0] seen;

    // Reset with all pins high: outputs zero, power-up rise after 6 cycles.
    rst_ = 1'b0;
    mon.pins_in = 4'hF;
    mon.clr_changed = 4'h0;
    tick(3);
    check_all_zero("reset");
    rst_ = 1'b1;
    tick(5);
    check("pwrup_rise_early", 32'(mon.rise), 32'h0);
    tick();
    check("pwrup_rise",   32'(mon.rise),        32'hF);
    check("pwrup_stable", 32'(mon.pins_stable), 32'hF);
    tick();
    check("pwrup_rise_1cyc", 32'(mon.rise),     32'h0);
    check("pwrup_cnt",       32'(mon.edge_cnt), 32'h4);
    check("pwrup_changed",   32'(mon.changed),  32'hF);

    mon.clr_changed = 4'hF;
    tick();
    mon.clr_changed = 4'h0;
    check("clr_all", 32'(mon.changed), 32'h0);

    // All pins back low.
    mon.pins_in = 4'h0;
    tick(6);
    check("fall_all",        32'(mon.fall), 32'hF);
    check("fall_all_norise", 32'(mon.rise), 32'h0);
    tick();
    check("fall_all_cnt", 32'(mon.edge_cnt), 32'h8);
    mon.clr_changed = 4'hF;
    tick();
    mon.clr_changed = 4'h0;

    // Glitch: 3-cycle high pulse on pin 0 is rejected.
    seen = 4'h0;
    mon.pins_in[0] = 1'b1;
    tick(3);
    mon.pins_in[0] = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      seen = seen | mon.rise | mon.fall;
    end
    check("glitch_pulses", 32'(seen),            32'h0);
    check("glitch_stable", 32'(mon.pins_stable), 32'h0);
    check("glitch_cnt",    32'(mon.edge_cnt),    32'h8);

    // Bounce on pin 1: 1,0,1 then hold 1.
    rise_at = -1;
    nrise = 0;
    seen = 4'h0;
    for (int t = 1; t <= 12; t++) begin
      mon.pins_in[1] = (t == 2) ? 1'b0 : 1'b1;
      tick();
      if (mon.rise[1]) begin
        nrise++;
        if (rise_at < 0) rise_at = t;
      end
      seen = seen | (mon.rise & 4'b1101) | mon.fall;
    end
    check("bounce_nrise",  32'(nrise),           32'd1);
    check("bounce_rise_t", 32'(rise_at),         32'd8);
    check("bounce_other",  32'(seen),            32'h0);
    check("bounce_cnt",    32'(mon.edge_cnt),    32'h9);
    check("bounce_stable", 32'(mon.pins_stable), 32'h2);

    // Clear race on pin 2: set wins, then lone clear takes effect.
    mon.pins_in[2] = 1'b1;
    tick(6);
    check("race_rise2", 32'(mon.rise), 32'h4);
    tick();
    mon.pins_in[2] = 1'b0;
    tick(6);
    check("race_fall2", 32'(mon.fall), 32'h4);
    mon.clr_changed = 4'h4;
    tick();
    mon.clr_changed = 4'h0;
    check("race_set_wins", 32'(mon.changed), 32'h6);
    check("race_cnt",      32'(mon.edge_cnt), 32'hB);
    mon.clr_changed = 4'h4;
    tick();
    mon.clr_changed = 4'h0;
    check("race_clear", 32'(mon.changed), 32'h2);

    // Reset back to a zero count, then 4 simultaneous toggles wrap edge_cnt.
    mon.pins_in = 4'h0;
    rst_ = 1'b0;
    tick(2);
    check_all_zero("reset2");
    rst_ = 1'b1;
    tick(2);
    for (int k = 0; k < 4; k++) begin
      mon.pins_in = (k % 2 == 0) ? 4'hF : 4'h0;
      tick(6);
      check($sformatf("wrap_pulse%0d", k),
            32'((k % 2 == 0) ? mon.rise : mon.fall), 32'hF);
      tick();
      check($sformatf("wrap_cnt%0d", k), 32'(mon.edge_cnt), 32'(((k + 1) * 4) % 16));
    end

    // Reset mid-debounce on pin 0: partial count discarded.
    mon.pins_in = 4'h1;
    tick(4);
    check("mid_stable_pre", 32'(mon.pins_stable), 32'h0);
    rst_ = 1'b0;
    tick();
    check_all_zero("mid_rst");
    rst_ = 1'b1;
    rise_at = -1;
    seen = 4'h0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (mon.rise[0] && rise_at < 0) rise_at = t;
      seen = seen | mon.fall;
    end
    check("mid_rise_t", 32'(rise_at),         32'd6);
    check("mid_nofall", 32'(seen),            32'h0);
    check("mid_cnt",    32'(mon.edge_cnt),    32'h1);
    check("mid_stable", 32'(mon.pins_stable), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
